// File: rtl/vga_pkg.sv
// vga_pkg: shared 1280x1024 timing constants, RGB332 layout, colours and feeder states.
package vga_pkg;
  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, RESYNC} state_t;
  localparam int H_VIS_DEF = 1280;
  localparam int V_VIS_DEF = 1024;
  localparam int CNT_W_DEF = 11;
  localparam int R_LSB = 0;
  localparam int G_LSB = 3;
  localparam int B_LSB = 6;
  function automatic logic [7:0] rgb332(logic [2:0] r, logic [2:0] g, logic [1:0] b);
    return (8'(r) << R_LSB) | (8'(g) << G_LSB) | (8'(b) << B_LSB);
  endfunction
  localparam logic [7:0] BLANK_DEF = rgb332(3'd0, 3'd0, 2'd0);
  localparam logic [7:0] UNDER_DEF = rgb332(3'd7, 3'd0, 2'd0);
endpackage

// File: rtl/vga_pixel_feeder_if.sv
// vga_pixel_feeder_if: producer-to-feeder pixel valid/ready handshake.
interface vga_pixel_feeder_if;
  logic [7:0] wr_data;
  logic wr_sof;
  logic wr_valid;
  logic wr_ready;
  modport master(output wr_data, wr_sof, wr_valid, input wr_ready);
  modport slave(input wr_data, wr_sof, wr_valid, output wr_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: pointer-based synchronous FIFO, no bypass, full/empty from the extra pointer MSB.
module sync_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign level = wr_ptr - rd_ptr;
  assign dout = mem[rd_ptr[ADDR_W-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[ADDR_W-1:0]] <= din;
endmodule

// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder: buffers RGB332 pixels and aligns them to the VGA counters, flagging underrun/misalignment.
// Define PIX_FEED_STATS_EN to add the underrun_cnt and frame_cnt statistics outputs.
module vga_pixel_feeder
  import vga_pkg::*;
#(
  parameter int VIS_H = H_VIS_DEF,
  parameter int VIS_V = V_VIS_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter logic [7:0] BLANK_COLOR = BLANK_DEF,
  parameter logic [7:0] UNDER_COLOR = UNDER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  vga_pixel_feeder_if.slave wr,
  input  logic [CNT_W-1:0]  hcnt,
  input  logic [CNT_W-1:0]  vcnt,
  input  logic              err_clr,
  output logic [7:0]        pix_data,
  output logic [ADDR_W:0]   level,
  output logic              underrun,
  output logic              sof_err
`ifdef PIX_FEED_STATS_EN
  ,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       frame_cnt
`endif
);
  logic [8:0] head;
  logic full, empty, pop, set_under, set_sof, vis, fs;
  logic [7:0] pix_nxt;
  state_t state, state_nxt;
  assign wr.wr_ready = !full && !rst;
  assign vis = (hcnt < CNT_W'(VIS_H)) && (vcnt < CNT_W'(VIS_V));
  assign fs = (hcnt == '0) && (vcnt == '0);
  sync_fifo #(.W(9), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(wr.wr_valid && wr.wr_ready),
    .pop(pop),
    .din({wr.wr_sof, wr.wr_data}),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    set_under = 1'b0;
    set_sof = 1'b0;
    pix_nxt = BLANK_COLOR;
    case (state)
      WAIT_FRAME: if (fs && !empty) begin
        pop = head[8];
        set_sof = !head[8];
        pix_nxt = head[8] ? head[7:0] : BLANK_COLOR;
        state_nxt = head[8] ? ACTIVE : RESYNC;
      end
      ACTIVE: if (vis) begin
        if (empty) begin
          pix_nxt = UNDER_COLOR;
          set_under = 1'b1;
          state_nxt = RESYNC;
        end else if (head[8] != fs) begin
          // early SOF waits for the next frame start; a late frame must drain first
          pix_nxt = UNDER_COLOR;
          set_sof = 1'b1;
          state_nxt = fs ? RESYNC : WAIT_FRAME;
        end else begin
          pop = 1'b1;
          pix_nxt = head[7:0];
        end
      end
      default: begin
        pix_nxt = vis ? UNDER_COLOR : BLANK_COLOR;
        pop = !empty && !head[8];
        state_nxt = (!empty && head[8]) ? WAIT_FRAME : RESYNC;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WAIT_FRAME;
      pix_data <= BLANK_COLOR;
      underrun <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pix_data <= pix_nxt;
      underrun <= set_under || (underrun && !err_clr);
      sof_err <= set_sof || (sof_err && !err_clr);
    end
`ifdef PIX_FEED_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      underrun_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (set_under) underrun_cnt <= underrun_cnt + 16'(underrun_cnt != 16'hFFFF);
      else if (err_clr) underrun_cnt <= '0;
      if (state == WAIT_FRAME && state_nxt == ACTIVE) frame_cnt <= frame_cnt + 16'd1;
    end
`endif
endmodule
